// File: rtl/ioctl_rom_router.sv
// ioctl_rom_router
// Packs the hps_io ioctl ROM download stream into DATA_W-wide little-endian
// words and routes each word to one of NUM_REG ROM regions by address window.
// Also captures the title-number byte and reports busy/done/err status.
// Optional feature macro: IOCTL_ROM_ROUTER_CKSUM_EN (16-bit wrapping byte sum).
module ioctl_rom_router #(
   parameter int unsigned           DATA_W    = 8,
   parameter int unsigned           NUM_REG   = 4,
   parameter logic [16*NUM_REG-1:0] REG_BASE  = {16'hC000, 16'h8000, 16'h4000, 16'h0000},
   parameter logic [16*NUM_REG-1:0] REG_SIZE  = {16'h4000, 16'h4000, 16'h4000, 16'h4000},
   parameter logic [7:0]            ROM_INDEX = 8'd0,
   parameter logic [7:0]            TNO_INDEX = 8'd1,
   parameter int unsigned           WADDR_W   = 14
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               ioctl_download,
   input  logic [7:0]         ioctl_index,
   input  logic               ioctl_wr,
   input  logic [24:0]        ioctl_addr,
   input  logic [7:0]         ioctl_dout,
   output logic [NUM_REG-1:0] rom_we,
   output logic [WADDR_W-1:0] rom_addr,
   output logic [DATA_W-1:0]  rom_data,
   output logic [7:0]         tno,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [15:0]        checksum
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned LB    = $clog2(BYTES);
   localparam int unsigned LBW   = (LB == 0) ? 1 : LB;
   localparam int unsigned RW    = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
   localparam logic [DATA_W-1:0] FILL = '1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         state;
   logic               dl_q;

   // partially assembled word and its tag
   logic [DATA_W-1:0]  buf_data;
   logic               buf_dirty;
   logic [RW-1:0]      buf_reg;
   logic [WADDR_W-1:0] buf_addr;

   // one-entry holding slot for a word completed on the same strobe as a flush
   logic               pend_vld;
   logic [DATA_W-1:0]  pend_data;
   logic [RW-1:0]      pend_reg;
   logic [WADDR_W-1:0] pend_addr;

   logic               hit;
   logic [RW-1:0]      hit_reg;
   logic [15:0]        hit_off;
   logic [WADDR_W-1:0] hit_addr;
   int unsigned        lane;
   logic               complete;
   logic               flush_old;
   logic [DATA_W-1:0]  merged;

   logic               dl_rise;
   logic               dl_fall;
   logic               rom_strobe;
   logic               rom_hit;
   logic               start_load;
   logic               pend_load;

   logic               em_vld;
   logic [RW-1:0]      em_reg;
   logic [WADDR_W-1:0] em_addr;
   logic [DATA_W-1:0]  em_data;
   logic [NUM_REG-1:0] em_we;

   assign dl_rise    = ioctl_download && !dl_q;
   assign dl_fall    = !ioctl_download && dl_q;
   assign rom_strobe = ioctl_wr && (ioctl_index == ROM_INDEX);
   assign rom_hit    = (state == S_LOAD) && rom_strobe && hit;
   assign start_load = (state == S_IDLE) && dl_rise && (ioctl_index == ROM_INDEX);
   // with a flush pending the buffer is always clean, so pend_vld never meets flush_old
   assign pend_load  = rom_hit && complete && (flush_old || pend_vld);

   // Region decode (lowest region wins), word address, lane merge and flush detect
   always_comb begin
      hit     = 1'b0;
      hit_reg = '0;
      hit_off = '0;
      for (int unsigned r = 0; r < NUM_REG; r++) begin
         if (!hit && (ioctl_addr[24:16] == 9'd0)
             && ({1'b0, ioctl_addr[15:0]} >= {1'b0, REG_BASE[16*r +: 16]})
             && ({1'b0, ioctl_addr[15:0]} <
                 ({1'b0, REG_BASE[16*r +: 16]} + {1'b0, REG_SIZE[16*r +: 16]}))) begin
            hit     = 1'b1;
            hit_reg = RW'(r);
            hit_off = ioctl_addr[15:0] - REG_BASE[16*r +: 16];
         end
      end
      hit_addr  = WADDR_W'(hit_off >> LB);
      lane      = 32'(ioctl_addr[LBW-1:0]) & (BYTES - 1);
      complete  = (lane == BYTES - 1);
      flush_old = buf_dirty && ((hit_reg != buf_reg) || (hit_addr != buf_addr));
      merged    = flush_old ? FILL : buf_data;
      for (int unsigned b = 0; b < BYTES; b++) begin
         if (b == lane) merged[8*b +: 8] = ioctl_dout;
      end
   end

   // Select the word to emit this cycle: flushed buffer, held word, or fresh word
   always_comb begin
      em_vld  = 1'b0;
      em_reg  = buf_reg;
      em_addr = buf_addr;
      em_data = buf_data;
      em_we   = '0;
      if (state == S_LOAD) begin
         if (rom_hit && flush_old) begin
            em_vld = 1'b1;
         end else if (pend_vld) begin
            em_vld  = 1'b1;
            em_reg  = pend_reg;
            em_addr = pend_addr;
            em_data = pend_data;
         end else if (rom_hit && complete) begin
            em_vld  = 1'b1;
            em_reg  = hit_reg;
            em_addr = hit_addr;
            em_data = merged;
         end
      end else if (state == S_FLUSH) begin
         if (pend_vld) begin
            em_vld  = 1'b1;
            em_reg  = pend_reg;
            em_addr = pend_addr;
            em_data = pend_data;
         end else if (buf_dirty) begin
            em_vld = 1'b1;
         end
      end
      for (int unsigned r = 0; r < NUM_REG; r++) begin
         em_we[r] = em_vld && (em_reg == RW'(r));
      end
   end

   // Transfer FSM, byte buffer, holding slot and status flags
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         dl_q      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         buf_data  <= FILL;
         buf_dirty <= 1'b0;
         buf_reg   <= '0;
         buf_addr  <= '0;
         pend_vld  <= 1'b0;
         pend_data <= FILL;
         pend_reg  <= '0;
         pend_addr <= '0;
      end else begin
         dl_q <= ioctl_download;
         case (state)
            S_IDLE: begin
               if (start_load) begin
                  state     <= S_LOAD;
                  busy      <= 1'b1;
                  err       <= 1'b0;
                  buf_data  <= FILL;
                  buf_dirty <= 1'b0;
                  pend_vld  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (rom_strobe && !hit) err <= 1'b1;
               if (rom_hit) begin
                  if (complete) begin
                     buf_data  <= FILL;
                     buf_dirty <= 1'b0;
                  end else begin
                     buf_data  <= merged;
                     buf_dirty <= 1'b1;
                     buf_reg   <= hit_reg;
                     buf_addr  <= hit_addr;
                  end
               end
               if (pend_load) begin
                  pend_vld  <= 1'b1;
                  pend_data <= merged;
                  pend_reg  <= hit_reg;
                  pend_addr <= hit_addr;
               end else begin
                  pend_vld  <= 1'b0;
               end
               if (dl_fall) state <= S_FLUSH;
            end
            S_FLUSH: begin
               pend_vld <= 1'b0;
               if (!pend_vld) begin
                  buf_data  <= FILL;
                  buf_dirty <= 1'b0;
               end
               if (!(pend_vld && buf_dirty)) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Registered ROM write port: one-cycle strobe, address/data held between writes
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rom_we   <= '0;
         rom_addr <= '0;
         rom_data <= '0;
      end else begin
         rom_we <= em_we;
         if (em_vld) begin
            rom_addr <= em_addr;
            rom_data <= em_data;
         end
      end
   end

   // Title number capture, independent of the ROM FSM
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tno <= 8'h00;
      end else if (ioctl_wr && (ioctl_index == TNO_INDEX) && (ioctl_addr == 25'd0)) begin
         tno <= ioctl_dout;
      end
   end

`ifdef IOCTL_ROM_ROUTER_CKSUM_EN
   // Wrapping sum of accepted ROM bytes; only changes while loading
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         checksum <= 16'h0000;
      end else if (start_load) begin
         checksum <= 16'h0000;
      end else if (rom_hit) begin
         checksum <= checksum + {8'h00, ioctl_dout};
      end
   end
`else
   assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Directed testbench for ioctl_rom_router: three instances (DATA_W 8/16/32)
// share one ioctl stream; each scenario checks the instance it targets.
module tb_ioctl_rom_router;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'h00;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = 8'h00;

   logic [3:0]  we8, we16, we32;
   logic [13:0] a8, a16, a32;
   logic [7:0]  d8;
   logic [15:0] d16;
   logic [31:0] d32;
   logic [7:0]  tno8, tno16, tno32;
   logic        busy8, busy16, busy32;
   logic        done8, done16, done32;
   logic        err8, err16, err32;
   logic [15:0] ck8, ck16, ck32;

   int vectors = 0;
   int miscompares = 0;

`ifdef IOCTL_ROM_ROUTER_CKSUM_EN
   localparam logic [15:0] CK_EXP = 16'h0102;
`else
   localparam logic [15:0] CK_EXP = 16'h0000;
`endif

   always #5 clk_sys = ~clk_sys;

   ioctl_rom_router #(.DATA_W(8)) u8 (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .rom_we(we8), .rom_addr(a8), .rom_data(d8),
      .tno(tno8), .busy(busy8), .done(done8), .err(err8), .checksum(ck8));

   ioctl_rom_router #(.DATA_W(16)) u16 (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .rom_we(we16), .rom_addr(a16), .rom_data(d16),
      .tno(tno16), .busy(busy16), .done(done16), .err(err16), .checksum(ck16));

   ioctl_rom_router #(.DATA_W(32)) u32 (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .rom_we(we32), .rom_addr(a32), .rom_data(d32),
      .tno(tno32), .busy(busy32), .done(done32), .err(err32), .checksum(ck32));

   task automatic tick();
      @(negedge clk_sys);
   endtask

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      tick();
   endtask

   task automatic end_dl();
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      repeat (4) tick();
   endtask

   task automatic put(input logic [24:0] a, input logic [7:0] d);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
   endtask

   task automatic test_reset();
      vectors++; if (we8 !== 4'b0000) begin miscompares++; $display("FAIL reset_we8: got %b expected 0000", we8); end
      vectors++; if (a8 !== 14'd0) begin miscompares++; $display("FAIL reset_addr8: got %h expected 0", a8); end
      vectors++; if (d8 !== 8'h00) begin miscompares++; $display("FAIL reset_data8: got %h expected 00", d8); end
      vectors++; if (d32 !== 32'h0) begin miscompares++; $display("FAIL reset_data32: got %h expected 0", d32); end
      vectors++; if ({busy8, done8, err8} !== 3'b000) begin miscompares++; $display("FAIL reset_flags8: got %b expected 000", {busy8, done8, err8}); end
      vectors++; if ({busy16, done16, err16} !== 3'b000) begin miscompares++; $display("FAIL reset_flags16: got %b expected 000", {busy16, done16, err16}); end
      vectors++; if (tno8 !== 8'h00) begin miscompares++; $display("FAIL reset_tno8: got %h expected 00", tno8); end
      vectors++; if (ck8 !== 16'h0000) begin miscompares++; $display("FAIL reset_ck8: got %h expected 0000", ck8); end
   endtask

   task automatic test_data8();
      logic [7:0] exp [4];
      exp = '{8'h11, 8'h22, 8'h33, 8'h44};
      start_dl(8'd0);
      vectors++; if (busy8 !== 1'b1) begin miscompares++; $display("FAIL data8_busy: got %b expected 1", busy8); end
      for (int i = 0; i <= 4; i++) begin
         if (i == 0) begin
            vectors++; if (we8 !== 4'b0000) begin miscompares++; $display("FAIL data8_we_idle: got %b expected 0000", we8); end
         end else begin
            vectors++; if (we8 !== 4'b0001) begin miscompares++; $display("FAIL data8_we[%0d]: got %b expected 0001", i-1, we8); end
            vectors++; if (a8 !== 14'(i-1)) begin miscompares++; $display("FAIL data8_addr[%0d]: got %h expected %h", i-1, a8, 14'(i-1)); end
            vectors++; if (d8 !== exp[i-1]) begin miscompares++; $display("FAIL data8_data[%0d]: got %h expected %h", i-1, d8, exp[i-1]); end
         end
         if (i < 4) put(25'(i), exp[i]);
         else ioctl_wr = 1'b0;
         tick();
      end
      vectors++; if (we8 !== 4'b0000) begin miscompares++; $display("FAIL data8_we_end: got %b expected 0000", we8); end
      end_dl();
      vectors++; if ({busy8, done8, err8} !== 3'b010) begin miscompares++; $display("FAIL data8_status: got busy/done/err %b expected 010", {busy8, done8, err8}); end
   endtask

   task automatic test_boundary();
      start_dl(8'd0);
      put(25'h03FFF, 8'hAA); tick();
      vectors++; if ({we8, a8, d8} !== {4'b0001, 14'h3FFF, 8'hAA}) begin miscompares++; $display("FAIL bound_3fff: got we=%b addr=%h data=%h expected 0001/3fff/aa", we8, a8, d8); end
      put(25'h04000, 8'hBB); tick();
      vectors++; if ({we8, a8, d8} !== {4'b0010, 14'h0000, 8'hBB}) begin miscompares++; $display("FAIL bound_4000: got we=%b addr=%h data=%h expected 0010/0000/bb", we8, a8, d8); end
      put(25'h0FFFF, 8'hCC); tick();
      vectors++; if ({we8, a8, d8} !== {4'b1000, 14'h3FFF, 8'hCC}) begin miscompares++; $display("FAIL bound_ffff: got we=%b addr=%h data=%h expected 1000/3fff/cc", we8, a8, d8); end
      end_dl();
      vectors++; if (err8 !== 1'b0) begin miscompares++; $display("FAIL bound_err: got %b expected 0", err8); end
   endtask

   task automatic test_pack16();
      start_dl(8'd0);
      put(25'h04000, 8'hAA); tick();
      vectors++; if (we16 !== 4'b0000) begin miscompares++; $display("FAIL pack16_we_half: got %b expected 0000", we16); end
      put(25'h04001, 8'hBB); tick();
      vectors++; if (we16 !== 4'b0010) begin miscompares++; $display("FAIL pack16_we: got %b expected 0010", we16); end
      vectors++; if (a16 !== 14'd0) begin miscompares++; $display("FAIL pack16_addr: got %h expected 0", a16); end
      vectors++; if (d16 !== 16'hBBAA) begin miscompares++; $display("FAIL pack16_data: got %h expected bbaa", d16); end
      ioctl_wr = 1'b0; tick();
      vectors++; if (we16 !== 4'b0000) begin miscompares++; $display("FAIL pack16_pulse: got %b expected 0000", we16); end
      vectors++; if (d16 !== 16'hBBAA) begin miscompares++; $display("FAIL pack16_hold: got %h expected bbaa", d16); end
      end_dl();
      vectors++; if ({busy16, done16} !== 2'b01) begin miscompares++; $display("FAIL pack16_status: got busy/done %b expected 01", {busy16, done16}); end
   endtask

   task automatic test_back_to_back();
      start_dl(8'd0);
      put(25'h00000, 8'h31); tick();
      vectors++; if (we16 !== 4'b0000) begin miscompares++; $display("FAIL b2b_we0: got %b expected 0000", we16); end
      put(25'h00003, 8'h32); tick();
      vectors++; if ({we16, a16, d16} !== {4'b0001, 14'd0, 16'hFF31}) begin miscompares++; $display("FAIL b2b_flush: got we=%b addr=%h data=%h expected 0001/0000/ff31", we16, a16, d16); end
      put(25'h00005, 8'h33); tick();
      vectors++; if ({we16, a16, d16} !== {4'b0001, 14'd1, 16'h32FF}) begin miscompares++; $display("FAIL b2b_pend: got we=%b addr=%h data=%h expected 0001/0001/32ff", we16, a16, d16); end
      ioctl_wr = 1'b0; tick();
      vectors++; if ({we16, a16, d16} !== {4'b0001, 14'd2, 16'h33FF}) begin miscompares++; $display("FAIL b2b_last: got we=%b addr=%h data=%h expected 0001/0002/33ff", we16, a16, d16); end
      tick();
      vectors++; if (we16 !== 4'b0000) begin miscompares++; $display("FAIL b2b_quiet: got %b expected 0000", we16); end
      end_dl();
   endtask

   task automatic test_flush32();
      start_dl(8'd0);
      put(25'h00002, 8'h5A); tick();
      ioctl_wr = 1'b0;
      vectors++; if ({we32, busy32} !== {4'b0000, 1'b1}) begin miscompares++; $display("FAIL flush32_pre: got we=%b busy=%b expected 0000/1", we32, busy32); end
      ioctl_download = 1'b0; tick();
      vectors++; if ({we32, busy32} !== {4'b0000, 1'b1}) begin miscompares++; $display("FAIL flush32_state: got we=%b busy=%b expected 0000/1", we32, busy32); end
      tick();
      vectors++; if (we32 !== 4'b0001) begin miscompares++; $display("FAIL flush32_we: got %b expected 0001", we32); end
      vectors++; if (a32 !== 14'd0) begin miscompares++; $display("FAIL flush32_addr: got %h expected 0", a32); end
      vectors++; if (d32 !== 32'hFF5AFFFF) begin miscompares++; $display("FAIL flush32_data: got %h expected ff5affff", d32); end
      vectors++; if ({busy32, done32} !== 2'b01) begin miscompares++; $display("FAIL flush32_status: got busy/done %b expected 01", {busy32, done32}); end
      repeat (2) tick();
   endtask

   task automatic test_err();
      start_dl(8'd0);
      put(25'h10000, 8'hEE); tick();
      ioctl_wr = 1'b0;
      vectors++; if ({err16, we16} !== {1'b1, 4'b0000}) begin miscompares++; $display("FAIL err_set: got err=%b we=%b expected 1/0000", err16, we16); end
      tick();
      vectors++; if (we16 !== 4'b0000) begin miscompares++; $display("FAIL err_nowe: got %b expected 0000", we16); end
      end_dl();
      vectors++; if ({err16, done16} !== 2'b11) begin miscompares++; $display("FAIL err_sticky: got err/done %b expected 11", {err16, done16}); end
      start_dl(8'd0);
      vectors++; if ({err16, busy16} !== 2'b01) begin miscompares++; $display("FAIL err_clear: got err/busy %b expected 01", {err16, busy16}); end
      end_dl();
   endtask

   task automatic test_tno();
      start_dl(8'd1);
      vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL tno_idle: got busy %b expected 0", busy8); end
      put(25'h00000, 8'h07); tick();
      vectors++; if ({tno8, we8} !== {8'h07, 4'b0000}) begin miscompares++; $display("FAIL tno_load: got tno=%h we=%b expected 07/0000", tno8, we8); end
      put(25'h00001, 8'h99); tick();
      ioctl_wr = 1'b0;
      vectors++; if (tno16 !== 8'h07) begin miscompares++; $display("FAIL tno_offset: got %h expected 07", tno16); end
      tick();
      vectors++; if (we8 !== 4'b0000) begin miscompares++; $display("FAIL tno_nowe: got %b expected 0000", we8); end
      end_dl();
      ioctl_index = 8'd0;
   endtask

   task automatic test_checksum();
      start_dl(8'd0);
      put(25'h00000, 8'h01); tick();
      put(25'h00001, 8'h02); tick();
      put(25'h00002, 8'hFF); tick();
      end_dl();
      vectors++; if (ck8 !== CK_EXP) begin miscompares++; $display("FAIL cksum8: got %h expected %h", ck8, CK_EXP); end
      vectors++; if (ck32 !== CK_EXP) begin miscompares++; $display("FAIL cksum32: got %h expected %h", ck32, CK_EXP); end
   endtask

   task automatic test_reset_mid();
      start_dl(8'd0);
      put(25'h00000, 8'hA1); tick();
      put(25'h00001, 8'hA2); tick();
      put(25'h00002, 8'hA3); tick();
      ioctl_wr = 1'b0;
      vectors++; if ({we32, busy32} !== {4'b0000, 1'b1}) begin miscompares++; $display("FAIL rmid_pre: got we=%b busy=%b expected 0000/1", we32, busy32); end
      reset_n = 1'b0;
      #1;
      vectors++; if ({we32, a32, d32} !== {4'b0000, 14'd0, 32'h0}) begin miscompares++; $display("FAIL rmid_port: got we=%b addr=%h data=%h expected all zero", we32, a32, d32); end
      vectors++; if ({busy32, done32, err32} !== 3'b000) begin miscompares++; $display("FAIL rmid_flags: got %b expected 000", {busy32, done32, err32}); end
      vectors++; if ({tno32, ck32} !== 24'h0) begin miscompares++; $display("FAIL rmid_tno_ck: got tno=%h ck=%h expected 00/0000", tno32, ck32); end
      tick();
      ioctl_download = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++; if ({we32, busy32, done32} !== 6'b0) begin miscompares++; $display("FAIL rmid_after[%0d]: got we=%b busy=%b done=%b expected 0000/0/0", i, we32, busy32, done32); end
      end
   endtask

   initial begin
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      test_reset();
      test_data8();
      test_boundary();
      test_pack16();
      test_back_to_back();
      test_flush32();
      test_err();
      test_tno();
      test_checksum();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/ioctl_rom_router.md
Name: ioctl_rom_router

Overview:
- Successor to the single-ROM, byte-wide download path in the arcade top level.
- Takes the hps_io ioctl download stream and packs bytes into DATA_W-wide words.
- Routes each word to one of NUM_REG ROM regions by address window.
- Captures the title-number byte from a separate ioctl index, and reports busy/done/error for reset gating.

Parameters:
- DATA_W, 8, output word width; legal values 8, 16, 32. BYTES = DATA_W/8, LB = log2(BYTES).
- NUM_REG, 4, number of ROM regions (1..4).
- REG_BASE, {16'hC000,16'h8000,16'h4000,16'h0000}, packed 16-bit byte base per region; region 0 is in the LSBs.
- REG_SIZE, {16'h4000,16'h4000,16'h4000,16'h4000}, packed 16-bit byte size per region; each size is a multiple of BYTES.
- ROM_INDEX, 0, ioctl_index value carrying ROM data.
- TNO_INDEX, 1, ioctl_index value carrying the title number.
- WADDR_W, 14, word-address output width.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  high for the duration of a transfer.
- ioctl_index  in  8  transfer type.
- ioctl_wr  in  1  one-cycle byte strobe; back-to-back strobes are legal.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- rom_we  out  NUM_REG  one-hot region write strobe.
- rom_addr  out  WADDR_W  word address within the region: (addr-base)>>LB.
- rom_data  out  DATA_W  packed word, little-endian (lowest byte address in bits [7:0]).
- tno  out  8  title number.
- busy  out  1  ROM transfer in progress, including the flush.
- done  out  1  sticky; at least one ROM transfer has completed.
- err  out  1  sticky; at least one byte fell outside every region.
- checksum  out  16  see Optional Feature.

Behaviour:
- Reset (async assert, sync release): rom_we=0, rom_addr=0, rom_data=0, tno=0, busy=0, done=0, err=0, checksum=0, byte buffer = all 8'hFF, FSM = IDLE.
- FSM states IDLE, LOAD, FLUSH, DONE:
  - IDLE -> LOAD on a rising edge of ioctl_download with ioctl_index==ROM_INDEX. On entry, clear err and checksum and set busy=1.
  - LOAD, per ioctl_wr: decode the region. Region r hits when base_r <= ioctl_addr[15:0] < base_r+size_r, and ioctl_addr[24:16]==0. The lowest r wins.
  - LOAD, miss: set err and drop the byte. The buffer is untouched.
  - LOAD, hit: if the word tag (region, word address) differs from the buffer tag and the buffer holds unwritten bytes, emit the buffer first as a flush. Then write the byte into lane ioctl_addr[LB-1:0].
  - LOAD, top lane (lane BYTES-1) written: issue a word write on the next cycle, then reset the buffer to 8'hFF fill.
  - LOAD -> FLUSH on the falling edge of ioctl_download.
  - FLUSH: if bytes are pending, emit one padded word (missing lanes 8'hFF). Then -> DONE.
  - DONE: done=1, busy=0; -> IDLE in the following cycle.
- Write timing: rom_we is a one-cycle pulse, registered one cycle after the completing ioctl_wr. rom_addr and rom_data are valid in the same cycle and held until the next write.
- Simultaneous flush and top-lane completion on one strobe:
  - The flush word goes out on cycle+1.
  - The new word (with DATA_W=8, it is always complete) goes out on cycle+2.
  - A one-entry pending register covers this case; a back-to-back stream never loses a byte.
- DATA_W=8: there is no packing; every hit produces a write on the next cycle.
- TNO_INDEX: in any state, ioctl_wr with ioctl_index==TNO_INDEX and ioctl_addr==0 loads tno. Other offsets are ignored. This path does not touch the FSM.
- Downloads with another index leave the FSM in IDLE and produce no rom_we.
- Reset mid-transfer aborts immediately: pending bytes are discarded and done stays 0.

Optional Feature:
- Macro IOCTL_ROM_ROUTER_CKSUM_EN.
- Defined: checksum is a 16-bit wrapping sum of every byte that hit a region in the current ROM transfer. It is cleared on LOAD entry and frozen from DONE onward.
- Undefined: checksum is tied to 16'h0000 and no adder is synthesised.

Test Plan:
- DATA_W=8, ROM download of addr 0..3 = 11,22,33,44 -> four region-0 rom_we pulses, each one cycle after its strobe; rom_addr 0..3; done=1; err=0.
- DATA_W=16, bytes AA,BB at 0x4000,0x4001 back-to-back -> one rom_we[1] pulse with rom_addr=0, rom_data=16'hBBAA.
- DATA_W=32, single byte 5A at 0x0002, then download falls -> FLUSH write rom_addr=0, rom_data=32'hFF5AFFFF; busy falls after FLUSH.
- Byte at ioctl_addr 0x10000 -> err=1, no rom_we. The next ROM download start clears err.
- Index 1, addr 0, data 07 during an idle period -> tno=8'h07, no rom_we. With the macro defined, ROM bytes 01,02,FF -> checksum=16'h0102.
- Assert reset_n low after 3 of 4 bytes (DATA_W=32) -> no rom_we, busy=0, done=0, all outputs at reset values.
